uart_rx: RTL and testbench

Serial-to-parallel UART receiver: 8 data bits, LSB first, one start bit, one stop bit, no parity. It sits on the FPGA's debug UART pin and is the receiving end of the existing `uart_tx` link, using the same `CLKS_PER_BIT` convention. It synchronizes the asynchronous line, validates the start bit at mid-bit, samples each bit at its centre, and delivers the byte with a one-cycle valid strobe, or flags a framing error.

---
 rtl/uart_rx.sv | 113 +++++++++++
 tb/tb_uart_rx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchronizer, mid-bit start validation,
// centre sampling of each bit, one-cycle DV or framing-error strobe.
module uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Frame_Err
);
  localparam logic [9:0] CPB_M1 = 10'(CLKS_PER_BIT - 1);
  localparam logic [9:0] HALF   = 10'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_CLEANUP, S_BREAK
  } state_t;

  state_t     state, state_n;
  logic       rx_meta, rx_s;
  logic [9:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shreg, shreg_n;
  logic [7:0] byte_q, byte_n;
  logic       dv_n, ferr_n;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      byte_q      <= '0;
      o_Rx_DV     <= 1'b0;
      o_Frame_Err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      shreg       <= shreg_n;
      byte_q      <= byte_n;
      o_Rx_DV     <= dv_n;
      o_Frame_Err <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    byte_n  = byte_q;
    dv_n    = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (!rx_s) state_n = S_START;
      end
      S_START: begin
        // Line must still be low at mid start bit, otherwise treat as glitch
        if (cnt < HALF) cnt_n = cnt + 10'd1;
        else if (!rx_s) begin
          cnt_n   = '0;
          state_n = S_DATA;
        end else state_n = S_IDLE;
      end
      S_DATA: begin
        if (cnt < CPB_M1) cnt_n = cnt + 10'd1;
        else begin
          cnt_n        = '0;
          shreg_n[idx] = rx_s;
          if (idx == 3'd7) state_n = S_STOP;
          else idx_n = idx + 3'd1;
        end
      end
      S_STOP: begin
        if (cnt < CPB_M1) cnt_n = cnt + 10'd1;
        else begin
          cnt_n = '0;
          if (rx_s) begin
            byte_n  = shreg;
            dv_n    = 1'b1;
            state_n = S_CLEANUP;
          end else begin
            ferr_n  = 1'b1;
            state_n = S_BREAK;
          end
        end
      end
      S_CLEANUP: state_n = S_IDLE;
      // Held-low line: wait for idle so a break yields a single error
      S_BREAK: if (rx_s) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign o_Rx_Byte   = byte_q;
  assign o_Rx_Active = (state != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: bit-level serial driver at CLKS_PER_BIT 4 and 87,
// received bytes compared against the queue of bytes that were sent.
module tb_uart_rx;
  logic       clk = 1'b0;
  logic       rst4_n = 1'b0, rst87_n = 1'b0;
  logic       rx4 = 1'b1, rx87 = 1'b1;
  logic       dv4, act4, ferr4, dv87, act87, ferr87;
  logic [7:0] byte4, byte87;

  int checks = 0, failures = 0;
  int cyc = 0;
  int dvcnt4 = 0, ferrcnt4 = 0, both4 = 0;
  int dvcnt87 = 0, ferrcnt87 = 0, both87 = 0, last_dv87 = -1;
  logic [7:0] q4[$], q87[$];

  uart_rx #(.CLKS_PER_BIT(4)) u_rx4 (
    .i_Clock(clk), .i_Reset_n(rst4_n), .i_Rx_Serial(rx4),
    .o_Rx_DV(dv4), .o_Rx_Byte(byte4), .o_Rx_Active(act4), .o_Frame_Err(ferr4)
  );
  uart_rx #(.CLKS_PER_BIT(87)) u_rx87 (
    .i_Clock(clk), .i_Reset_n(rst87_n), .i_Rx_Serial(rx87),
    .o_Rx_DV(dv87), .o_Rx_Byte(byte87), .o_Rx_Active(act87), .o_Frame_Err(ferr87)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dv4) begin q4.push_back(byte4); dvcnt4++; end
    if (ferr4) ferrcnt4++;
    if (dv4 && ferr4) both4++;
    if (dv87) begin q87.push_back(byte87); dvcnt87++; last_dv87 = cyc; end
    if (ferr87) ferrcnt87++;
    if (dv87 && ferr87) both87++;
  end

  task automatic drive(input bit sel, input logic v);
    if (sel) rx87 = v; else rx4 = v;
  endtask

  // Called on a negedge; returns the posedge count at the falling start edge
  task automatic send(input bit sel, input logic [7:0] b, input int per,
                      input bit stopv, output int p);
    p = cyc;
    drive(sel, 1'b0);
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(sel, b[i]);
      repeat (per) @(negedge clk);
    end
    drive(sel, stopv);
    repeat (per) @(negedge clk);
  endtask

  task automatic test_reset;
    rst4_n = 1'b0; rst87_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({dv4, ferr4, act4} !== 3'b000) begin failures++; $display("FAIL reset_ctl4 got=%b exp=000", {dv4, ferr4, act4}); end
    checks++; if (byte4 !== 8'h00) begin failures++; $display("FAIL reset_byte4 got=%h exp=00", byte4); end
    checks++; if ({dv87, ferr87, act87} !== 3'b000) begin failures++; $display("FAIL reset_ctl87 got=%b exp=000", {dv87, ferr87, act87}); end
    checks++; if (byte87 !== 8'h00) begin failures++; $display("FAIL reset_byte87 got=%h exp=00", byte87); end
    rst4_n = 1'b1; rst87_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (act4 !== 1'b0 || act87 !== 1'b0) begin failures++; $display("FAIL idle_active got=%b%b exp=00", act4, act87); end
  endtask

  task automatic test_back_to_back;
    int p;
    int f0 = ferrcnt4;
    q4.delete();
    send(0, 8'hA5, 4, 1, p);
    send(0, 8'h3C, 4, 1, p);
    repeat (20) @(negedge clk);
    checks++; if (q4.size() !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", q4.size()); end
    else begin
      checks++; if (q4[0] !== 8'hA5) begin failures++; $display("FAIL b2b_byte0 got=%h exp=a5", q4[0]); end
      checks++; if (q4[1] !== 8'h3C) begin failures++; $display("FAIL b2b_byte1 got=%h exp=3c", q4[1]); end
    end
    checks++; if (ferrcnt4 !== f0) begin failures++; $display("FAIL b2b_ferr got=%0d exp=%0d", ferrcnt4, f0); end
  endtask

  task automatic test_random;
    int p;
    logic [7:0] exp_q[$];
    q4.delete();
    for (int n = 0; n < 8; n++) begin
      logic [7:0] b;
      b = 8'($urandom);
      exp_q.push_back(b);
      send(0, b, 4, 1, p);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 7)) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    checks++; if (q4.size() !== exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", q4.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (q4[i] !== exp_q[i]) begin failures++; $display("FAIL rand_byte%0d got=%h exp=%h", i, q4[i], exp_q[i]); end
    end
  endtask

  task automatic test_glitch;
    int d0 = dvcnt4, f0 = ferrcnt4;
    rx4 = 1'b0;
    @(negedge clk);
    rx4 = 1'b1;
    repeat (12) @(negedge clk);
    checks++; if (act4 !== 1'b0) begin failures++; $display("FAIL glitch_active got=%b exp=0", act4); end
    checks++; if (dvcnt4 !== d0 || ferrcnt4 !== f0) begin failures++; $display("FAIL glitch_pulses got dv=%0d ferr=%0d exp dv=%0d ferr=%0d", dvcnt4, ferrcnt4, d0, f0); end
  endtask

  task automatic test_frame_err;
    int p;
    logic [7:0] prev = byte4;
    int d0 = dvcnt4, f0 = ferrcnt4;
    send(0, 8'h55, 4, 0, p);
    repeat (40) @(negedge clk);
    checks++; if (act4 !== 1'b1) begin failures++; $display("FAIL break_active got=%b exp=1", act4); end
    checks++; if (byte4 !== prev) begin failures++; $display("FAIL ferr_byte_hold got=%h exp=%h", byte4, prev); end
    rx4 = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (ferrcnt4 !== f0 + 1) begin failures++; $display("FAIL ferr_count got=%0d exp=%0d", ferrcnt4, f0 + 1); end
    checks++; if (dvcnt4 !== d0) begin failures++; $display("FAIL ferr_no_dv got=%0d exp=%0d", dvcnt4, d0); end
    checks++; if (act4 !== 1'b0) begin failures++; $display("FAIL break_release got=%b exp=0", act4); end
    q4.delete();
    send(0, 8'h81, 4, 1, p);
    repeat (12) @(negedge clk);
    checks++; if (q4.size() !== 1 || q4[0] !== 8'h81) begin failures++; $display("FAIL after_ferr got n=%0d b=%h exp n=1 b=81", q4.size(), byte4); end
    checks++; if (both4 !== 0) begin failures++; $display("FAIL dv_ferr_overlap4 got=%0d exp=0", both4); end
  endtask

  task automatic test_reset_mid;
    int p;
    q4.delete();
    fork
      send(0, 8'hFF, 4, 1, p);
      begin
        repeat (21) @(negedge clk);
        rst4_n = 1'b0;
        @(negedge clk);
        checks++; if ({dv4, ferr4, act4} !== 3'b000 || byte4 !== 8'h00) begin failures++; $display("FAIL mid_reset_outs got=%b/%h exp=000/00", {dv4, ferr4, act4}, byte4); end
        @(negedge clk);
        rst4_n = 1'b1;
      end
    join
    repeat (10) @(negedge clk);
    checks++; if (q4.size() !== 0) begin failures++; $display("FAIL aborted_dv got=%0d exp=0", q4.size()); end
    send(0, 8'h12, 4, 1, p);
    repeat (12) @(negedge clk);
    checks++; if (q4.size() !== 1 || byte4 !== 8'h12) begin failures++; $display("FAIL post_reset got n=%0d b=%h exp n=1 b=12", q4.size(), byte4); end
  endtask

  task automatic test_baud;
    int p, exp_cyc;
    int pers[2] = '{84, 90};
    logic [7:0] exp_q[$];
    q87.delete();
    for (int r = 0; r < 2; r++) begin
      logic [7:0] bl[4];
      bl[0] = 8'h00; bl[1] = 8'hFF; bl[2] = 8'h5A; bl[3] = 8'($urandom);
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back(bl[k]);
        send(1, bl[k], pers[r], 1, p);
        repeat (20) @(negedge clk);
      end
    end
    checks++; if (q87.size() !== exp_q.size()) begin failures++; $display("FAIL baud_count got=%0d exp=%0d", q87.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (q87[i] !== exp_q[i]) begin failures++; $display("FAIL baud_byte%0d got=%h exp=%h", i, q87[i], exp_q[i]); end
    end
    // Nominal-rate latency: fall seen by IDLE 3 edges later, DV follows stop sample
    send(1, 8'hC3, 87, 1, p);
    repeat (60) @(negedge clk);
    exp_cyc = p + 3 + (87 - 1) / 2 + 9 * 87 + 1;
    checks++; if (last_dv87 !== exp_cyc) begin failures++; $display("FAIL dv_latency got=%0d exp=%0d", last_dv87, exp_cyc); end
    checks++; if (byte87 !== 8'hC3) begin failures++; $display("FAIL nominal_byte got=%h exp=c3", byte87); end
    checks++; if (ferrcnt87 !== 0 || both87 !== 0) begin failures++; $display("FAIL baud_ferr got=%0d/%0d exp=0/0", ferrcnt87, both87); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_random();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_baud();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
